centroid_divider: RTL and testbench

Iterative divider stage that consumes the per-cluster channel totals and pixel count from the engine reduction tree and produces the updated 8-bit RGB centroid for that cluster. It sits directly downstream of the summation stage and upstream of the centroid register file and convergence controller. One shared restoring divider is time-multiplexed across red, green and blue. The stage also flags empty clusters and reports whether the centroid moved beyond a threshold.

---
 rtl/centroid_divider.sv | 175 +++++++++++++++++
 tb/tb_centroid_divider.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_divider.sv
// centroid_divider: turns per-cluster channel totals and a pixel count into an
// updated 8-bit RGB centroid. One restoring divider is reused for R, G and B,
// one quotient bit per cycle. Empty clusters keep their old centroid.
// Build option: define CENTROID_ROUND_EN for round-half-up quotients (one
// extra iteration per channel); undefined gives truncating quotients.
module centroid_divider #(
  parameter int unsigned SumWidth       = 26,
  parameter int unsigned CountWidth     = 14,
  parameter int unsigned PixWidth       = 8,
  parameter int unsigned ClusterIdWidth = 4,
  parameter int unsigned Threshold      = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SumWidth-1:0]       red_sum,
  input  logic [SumWidth-1:0]       green_sum,
  input  logic [SumWidth-1:0]       blue_sum,
  input  logic [CountWidth-1:0]     co_sum,
  input  logic [3*PixWidth-1:0]     old_centroid,
  input  logic [ClusterIdWidth-1:0] in_cluster,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3*PixWidth-1:0]     new_centroid,
  output logic [ClusterIdWidth-1:0] out_cluster,
  output logic                      out_empty,
  output logic                      out_changed
);

`ifdef CENTROID_ROUND_EN
  localparam int unsigned DivWidth = SumWidth + 1;
`else
  localparam int unsigned DivWidth = SumWidth;
`endif
  localparam int unsigned CntWidth = $clog2(DivWidth + 1);
  localparam logic [CntWidth-1:0] LastIter = CntWidth'(DivWidth - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StDivR = 3'd1;
  localparam logic [2:0] StDivG = 3'd2;
  localparam logic [2:0] StDivB = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]                state;
  logic [SumWidth-1:0]       green_q, blue_q;
  logic [CountWidth-1:0]     co_q;
  logic [3*PixWidth-1:0]     old_q;
  logic [ClusterIdWidth-1:0] cluster_q;
  logic                      empty_q;
  logic [PixWidth-1:0]       q_r, q_g, q_b;
  logic [CntWidth-1:0]       cnt;
  // dq holds the not-yet-consumed dividend bits; quotient bits shift in at the LSB
  logic [DivWidth-1:0]       dq, dq_nxt;
  logic [CountWidth:0]       rem, rem_sh, rem_nxt, div_ext;
  logic                      take;
  logic [PixWidth-1:0]       quot_sat;

  function automatic logic [DivWidth-1:0] make_dividend(input logic [SumWidth-1:0]   s,
                                                        input logic [CountWidth-1:0] c);
`ifdef CENTROID_ROUND_EN
    return DivWidth'(s) + DivWidth'(c >> 1);
`else
    if (c == '0) return s;
    return s;
`endif
  endfunction

  function automatic logic moved(input logic [PixWidth-1:0] a, input logic [PixWidth-1:0] b);
    logic [PixWidth:0] d;
    d = (a > b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return d > (PixWidth + 1)'(Threshold);
  endfunction

  // One restoring-division step plus saturation of the resulting quotient
  always_comb begin
    rem_sh   = {rem[CountWidth-1:0], dq[DivWidth-1]};
    div_ext  = {1'b0, co_q};
    take     = rem_sh >= div_ext;
    rem_nxt  = take ? (rem_sh - div_ext) : rem_sh;
    dq_nxt   = {dq[DivWidth-2:0], take};
    quot_sat = (|dq_nxt[DivWidth-1:PixWidth]) ? '1 : dq_nxt[PixWidth-1:0];
  end

  // Control FSM, operand latches, divider state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      new_centroid <= '0;
      out_cluster  <= '0;
      out_empty    <= 1'b0;
      out_changed  <= 1'b0;
      green_q      <= '0;
      blue_q       <= '0;
      co_q         <= '0;
      old_q        <= '0;
      cluster_q    <= '0;
      empty_q      <= 1'b0;
      q_r          <= '0;
      q_g          <= '0;
      q_b          <= '0;
      cnt          <= '0;
      dq           <= '0;
      rem          <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            green_q   <= green_sum;
            blue_q    <= blue_sum;
            co_q      <= co_sum;
            old_q     <= old_centroid;
            cluster_q <= in_cluster;
            empty_q   <= (co_sum == '0);
            dq        <= make_dividend(red_sum, co_sum);
            rem       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            state     <= (co_sum == '0) ? StDone : StDivR;
          end
        end
        StDivR, StDivG, StDivB: begin
          rem <= rem_nxt;
          dq  <= dq_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LastIter) begin
            cnt <= '0;
            rem <= '0;
            case (state)
              StDivR: begin
                q_r   <= quot_sat;
                dq    <= make_dividend(green_q, co_q);
                state <= StDivG;
              end
              StDivG: begin
                q_g   <= quot_sat;
                dq    <= make_dividend(blue_q, co_q);
                state <= StDivB;
              end
              default: begin
                q_b   <= quot_sat;
                state <= StDone;
              end
            endcase
          end
        end
        StDone: begin
          // First DONE cycle publishes the result; later cycles wait for the consumer
          if (!out_valid) begin
            out_valid   <= 1'b1;
            out_cluster <= cluster_q;
            out_empty   <= empty_q;
            if (empty_q) begin
              new_centroid <= old_q;
              out_changed  <= 1'b0;
            end else begin
              new_centroid <= {q_r, q_g, q_b};
              out_changed  <= moved(q_r, old_q[3*PixWidth-1 -: PixWidth]) |
                              moved(q_g, old_q[2*PixWidth-1 -: PixWidth]) |
                              moved(q_b, old_q[PixWidth-1:0]);
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_divider.sv
// Self-checking bench for centroid_divider: directed steps, scoreboard of
// expected results, immediate assertions at every comparison.
module tb_centroid_divider;
  localparam int SW = 26;
  localparam int CW = 14;
  localparam int TH = 1;
`ifdef CENTROID_ROUND_EN
  localparam int ITER = SW + 1;
`else
  localparam int ITER = SW;
`endif
  localparam int LAT = 3 * ITER + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] red_sum = '0, green_sum = '0, blue_sum = '0;
  logic [CW-1:0] co_sum = '0;
  logic [23:0]   old_centroid = '0;
  logic [3:0]    in_cluster = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [23:0]   new_centroid;
  logic [3:0]    out_cluster;
  logic          out_empty;
  logic          out_changed;

  centroid_divider dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .red_sum     (red_sum),
    .green_sum   (green_sum),
    .blue_sum    (blue_sum),
    .co_sum      (co_sum),
    .old_centroid(old_centroid),
    .in_cluster  (in_cluster),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .new_centroid(new_centroid),
    .out_cluster (out_cluster),
    .out_empty   (out_empty),
    .out_changed (out_changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] cen;
    logic [3:0]  cl;
    logic        empty;
    logic        changed;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [7:0] model_chan(input logic [SW-1:0] s, input logic [CW-1:0] c);
    longint unsigned d, q;
    d = longint'(s);
`ifdef CENTROID_ROUND_EN
    d = d + longint'(c >> 1);
`endif
    q = d / longint'(c);
    return (q > 255) ? 8'hff : q[7:0];
  endfunction

  function automatic logic model_moved(input logic [7:0] a, input logic [7:0] b);
    int d;
    d = (a > b) ? (int'(a) - int'(b)) : (int'(b) - int'(a));
    return d > TH;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [SW-1:0] r, input logic [SW-1:0] g, input logic [SW-1:0] b,
                       input logic [CW-1:0] c, input logic [23:0] old, input logic [3:0] cl);
    exp_t e;
    e.cl = cl;
    if (c == 0) begin
      e.cen = old; e.empty = 1'b0 | 1'b1; e.changed = 1'b0; e.lat = 1;
    end else begin
      e.cen     = {model_chan(r, c), model_chan(g, c), model_chan(b, c)};
      e.empty   = 1'b0;
      e.changed = model_moved(e.cen[23:16], old[23:16]) | model_moved(e.cen[15:8], old[15:8]) |
                  model_moved(e.cen[7:0], old[7:0]);
      e.lat     = LAT;
    end
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    red_sum = r; green_sum = g; blue_sum = b; co_sum = c;
    old_centroid = old; in_cluster = cl; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Waits for out_valid, compares against the scoreboard head, completes the
  // handshake when out_ready is high.
  task automatic collect();
    int   n;
    bit   seen;
    exp_t e;
    n = 0; seen = 0;
    while (!seen && n < 400) begin
      @(posedge clk);
      #1 n++;
      if (out_valid) seen = 1;
    end
    check("out_valid_timeout", 32'(seen), 32'd1);
    check("scoreboard_nonempty", 32'(sb.size() > 0), 32'd1);
    if (!seen || sb.size() == 0) return;
    e = sb.pop_front();
    last_exp = e;
    check("latency", n, e.lat);
    check("new_centroid", 32'(new_centroid), 32'(e.cen));
    check("out_cluster", 32'(out_cluster), 32'(e.cl));
    check("out_empty", 32'(out_empty), 32'(e.empty));
    check("out_changed", 32'(out_changed), 32'(e.changed));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    if (out_ready) begin
      @(posedge clk);
      #1;
      check("out_valid_after_xfer", 32'(out_valid), 32'd0);
      check("in_ready_after_xfer", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [CW-1:0] c;
    logic [SW-1:0] r, g, b;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_centroid", 32'(new_centroid), 32'd0);
    check("rst_flags", 32'({out_cluster, out_empty, out_changed}), 32'd0);
    @(negedge clk) reset = 1'b0;

    // Basic division
    drive(26'd1000, 26'd2000, 26'd500, 14'd10, 24'h000000, 4'd3);
    collect();
    check("basic_literal", 32'(last_exp.cen), 32'h64c832);
    // Empty cluster keeps old centroid
    drive(26'd7, 26'd8, 26'd9, 14'd0, {8'd12, 8'd34, 8'd56}, 4'd5);
    collect();
    // Truncate vs round
    drive(26'd15, 26'd0, 26'd0, 14'd4, 24'h030000, 4'd1);
    collect();
    // Saturation, delta 1 not counted as a change
    drive(26'd3000, 26'd500, 26'd200, 14'd10, {8'd254, 8'd50, 8'd20}, 4'd9);
    collect();
    // Boundaries at co_sum=1 and largest count
    drive(26'd255, 26'd256, 26'd0, 14'd1, 24'hff0000, 4'd15);
    collect();
    drive(26'h3ffffff, 26'd16383, 26'd0, 14'h3fff, 24'hffff00, 4'd0);
    collect();
    // Random operands
    for (int i = 0; i < 5; i++) begin
      c = 14'($urandom_range(1, 16383));
      r = 26'($urandom_range(0, int'(c) * 300));
      g = 26'($urandom_range(0, int'(c) * 256));
      b = 26'($urandom_range(0, int'(c) * 200));
      drive(r, g, b, c, 24'($urandom), 4'($urandom));
      collect();
    end

    // Backpressure: result must hold, new operands must be ignored
    out_ready = 1'b0;
    drive(26'd1234, 26'd5678, 26'd910, 14'd11, 24'h102030, 4'd6);
    collect();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      red_sum = 26'd99; green_sum = 26'd98; blue_sum = 26'd97; co_sum = 14'd0;
      old_centroid = 24'habcdef; in_cluster = 4'd2; in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_hold", 32'({out_valid, in_ready, new_centroid, out_cluster, out_empty,
                            out_changed}),
            32'({1'b1, 1'b0, last_exp.cen, last_exp.cl, last_exp.empty, last_exp.changed}));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    drive(26'd4000, 26'd300, 26'd20, 14'd20, 24'hc80f01, 4'd7);
    collect();

    // Reset while dividing green
    drive(26'd800, 26'd900, 26'd1000, 14'd8, 24'h000000, 4'd4);
    repeat (ITER + 5) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_outputs", 32'({new_centroid, out_cluster, out_empty, out_changed}), 32'd0);
    sb.delete();
    @(negedge clk) reset = 1'b0;
    drive(26'd2550, 26'd1270, 26'd10, 14'd10, 24'hff7f01, 4'd8);
    collect();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
